// File: rtl/jtframe_romarb_pkg.sv
// Shared types and the round-robin grant helper for the four-slot SDRAM ROM arbiter.
package jtframe_romarb_pkg;

  localparam int NSLOT = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_RDY = 2'd2
  } romarb_state_e;

  // First set bit of miss, scanning upward from last+1 and wrapping around.
  function automatic logic [1:0] rr_pick(input logic [NSLOT-1:0] miss, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last + 2'd1;
    found   = 1'b0;
    for (int k = 1; k <= NSLOT; k++) begin
      idx = last + 2'(k);
      if (!found && miss[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/jtframe_romarb_slot.sv
// One-entry read cache for a single requester; answers repeated addresses locally.
module jtframe_romarb_slot
  import jtframe_romarb_pkg::*;
#(
  parameter int AW = 22,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          wr,
  input  logic          clr,
  input  logic [AW-1:0] addr_in,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] data_in,
  output logic          hit,
  output logic [DW-1:0] dout
);

  logic          r_valid;
  logic [AW-1:0] r_caddr;
  logic [DW-1:0] r_cdata;

  // Cache entry: invalidation wins over a fill landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_caddr <= {AW{1'b0}};
      r_cdata <= {DW{1'b0}};
    end else if (clr) begin
      r_valid <= 1'b0;
    end else if (wr) begin
      r_valid <= 1'b1;
      r_caddr <= wr_addr;
      r_cdata <= data_in;
    end
  end

  assign hit  = req & r_valid & (addr_in == r_caddr);
  assign dout = r_cdata;

endmodule

// File: rtl/jtframe_romarb.sv
// Four-slot SDRAM read arbiter: per-slot one-entry caches, misses scheduled round-robin
// onto a single controller port, one transaction outstanding at a time.
module jtframe_romarb
  import jtframe_romarb_pkg::*;
#(
  parameter int AW = 22,
  parameter int DW = 32
) (
  input  logic                clk_rom,
  input  logic                rst_n,
  input  logic                downloading,
  input  logic                loop_rst,
  input  logic [NSLOT-1:0]    slot_req,
  input  logic [NSLOT*AW-1:0] slot_addr,
  output logic [NSLOT-1:0]    slot_ok,
  output logic [NSLOT*DW-1:0] slot_dout,
  output logic                sdram_req,
  output logic [AW-1:0]       sdram_addr,
  input  logic                sdram_ack,
  input  logic [DW-1:0]       data_read,
  input  logic                data_rdy
);

  romarb_state_e    r_state;
  logic [1:0]       r_grant;
  logic [1:0]       r_last;

  logic [NSLOT-1:0] w_hit;
  logic [NSLOT-1:0] w_miss;
  logic [NSLOT-1:0] w_wr;
  logic [AW-1:0]    w_addr [NSLOT];
  logic [1:0]       w_pick;
  logic             w_abort;
  logic             w_done;

  assign w_abort = downloading | loop_rst;
  assign w_miss  = slot_req & ~w_hit;
  assign w_pick  = rr_pick(w_miss, r_last);
  assign slot_ok = w_hit;

  // Completion strobe: data accepted in WAIT_RDY, or ack+data together in WAIT_ACK.
  always_comb begin
    w_done = 1'b0;
    if (w_abort) begin
      w_done = 1'b0;
    end else if (r_state == WAIT_ACK) begin
      w_done = sdram_ack & data_rdy;
    end else if (r_state == WAIT_RDY) begin
      w_done = data_rdy;
    end else begin
      w_done = 1'b0;
    end
  end

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    assign w_addr[i] = slot_addr[i*AW +: AW];
    assign w_wr[i]   = w_done & (r_grant == 2'(i));

    jtframe_romarb_slot #(
      .AW (AW),
      .DW (DW)
    ) u_slot (
      .clk     (clk_rom),
      .rst_n   (rst_n),
      .req     (slot_req[i]),
      .wr      (w_wr[i]),
      .clr     (downloading),
      .addr_in (w_addr[i]),
      .wr_addr (sdram_addr),
      .data_in (data_read),
      .hit     (w_hit[i]),
      .dout    (slot_dout[i*DW +: DW])
    );
  end

  // Request FSM; an abort drops the request but leaves grant/last untouched.
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= {AW{1'b0}};
      r_grant    <= 2'd0;
      r_last     <= 2'd3;
    end else if (w_abort) begin
      r_state   <= IDLE;
      sdram_req <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_miss) begin
            r_grant    <= w_pick;
            sdram_addr <= w_addr[w_pick];
            sdram_req  <= 1'b1;
            r_state    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            r_state   <= data_rdy ? IDLE : WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (data_rdy) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          sdram_req <= 1'b0;
        end
      endcase
      if (w_done) begin
        r_last <= r_grant;
      end
    end
  end

endmodule

// File: tb/tb_jtframe_romarb.sv
// Bench for jtframe_romarb: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a transaction-level model of caches and the single request.
module tb_jtframe_romarb;

  localparam int AW = 22;
  localparam int DW = 32;

  logic            clk_rom = 1'b0;
  logic            rst_n;
  logic            downloading;
  logic            loop_rst;
  logic [3:0]      slot_req;
  logic [4*AW-1:0] slot_addr;
  logic [3:0]      slot_ok;
  logic [4*DW-1:0] slot_dout;
  logic            sdram_req;
  logic [AW-1:0]   sdram_addr;
  logic            sdram_ack;
  logic [DW-1:0]   data_read;
  logic            data_rdy;

  jtframe_romarb #(.AW(AW), .DW(DW)) dut (
    .clk_rom     (clk_rom),
    .rst_n       (rst_n),
    .downloading (downloading),
    .loop_rst    (loop_rst),
    .slot_req    (slot_req),
    .slot_addr   (slot_addr),
    .slot_ok     (slot_ok),
    .slot_dout   (slot_dout),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_ack   (sdram_ack),
    .data_read   (data_read),
    .data_rdy    (data_rdy)
  );

  always #5 clk_rom = ~clk_rom;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: cache contents and the one outstanding SDRAM transaction.
  bit            m_valid [4];
  logic [AW-1:0] m_caddr [4];
  logic [DW-1:0] m_cdata [4];
  bit            m_busy;
  bit            m_acked;
  int            m_grant;
  int            m_last;
  logic [AW-1:0] m_addr;
  logic [AW-1:0] grants [$];

  function automatic bit m_hit(input int i);
    return slot_req[i] && m_valid[i] && (slot_addr[i*AW +: AW] == m_caddr[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_caddr[i] = '0;
      m_cdata[i] = '0;
    end
    m_busy  = 1'b0;
    m_acked = 1'b0;
    m_grant = 0;
    m_last  = 3;
    m_addr  = '0;
  endtask

  task automatic model_edge();
    bit [3:0] miss;
    bit       found;
    for (int i = 0; i < 4; i++) miss[i] = slot_req[i] && !m_hit(i);
    if (downloading) begin
      for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    end
    if (downloading || loop_rst) begin
      m_busy  = 1'b0;
      m_acked = 1'b0;
    end else if (!m_busy) begin
      if (miss != 4'd0) begin
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          int s;
          s = (m_last + k) % 4;
          if (!found && miss[s]) begin
            m_grant = s;
            found   = 1'b1;
          end
        end
        m_addr  = slot_addr[m_grant*AW +: AW];
        m_busy  = 1'b1;
        m_acked = 1'b0;
      end
    end else begin
      if (sdram_ack) m_acked = 1'b1;
      if (m_acked && data_rdy) begin
        m_caddr[m_grant] = m_addr;
        m_cdata[m_grant] = data_read;
        m_valid[m_grant] = 1'b1;
        m_last           = m_grant;
        m_busy           = 1'b0;
        m_acked          = 1'b0;
      end
    end
  endtask

  task automatic sample();
    logic [3:0]      eok;
    logic [4*DW-1:0] edout;
    @(negedge clk_rom);
    for (int i = 0; i < 4; i++) begin
      eok[i]               = m_hit(i);
      edout[i*DW +: DW]    = m_cdata[i];
    end
    check("slot_ok", 128'(slot_ok), 128'(eok));
    check("slot_dout", 128'(slot_dout), 128'(edout));
    check("sdram_req", 128'(sdram_req), 128'(m_busy && !m_acked));
    check("sdram_addr", 128'(sdram_addr), 128'(m_addr));
  endtask

  task automatic advance();
    model_edge();
    @(posedge clk_rom);
    #1;
  endtask

  task automatic set_req(input int i, input logic on, input logic [AW-1:0] addr);
    slot_req[i]              = on;
    slot_addr[i*AW +: AW]    = addr;
  endtask

  task automatic ctl_random();
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    data_read = $urandom;
    if (m_busy && !m_acked) begin
      if ($urandom_range(0, 2) == 0) begin
        sdram_ack = 1'b1;
        data_rdy  = ($urandom_range(0, 3) == 0);
      end else begin
        data_rdy  = ($urandom_range(0, 5) == 0);
      end
    end else if (m_busy) begin
      data_rdy = ($urandom_range(0, 2) == 0);
    end else begin
      data_rdy = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    downloading = 1'b0;
    loop_rst    = 1'b0;
    sdram_ack   = 1'b0;
    data_rdy    = 1'b0;
    data_read   = '0;
    slot_req    = '0;
    slot_addr   = '0;
    model_reset();
    sample();
    sample();
    rst_n = 1'b1;
    @(posedge clk_rom);
    #1;
  endtask

  task automatic run_capture(input int max_cycles, input int want);
    bit prev = 1'b0;
    grants.delete();
    for (int c = 0; c < max_cycles && grants.size() < want; c++) begin
      ctl_random();
      sample();
      if (sdram_req && !prev) grants.push_back(sdram_addr);
      prev = sdram_req;
      advance();
    end
  endtask

  task automatic drain(input int max_cycles);
    for (int c = 0; c < max_cycles && m_busy; c++) begin
      ctl_random();
      sample();
      advance();
    end
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr(input int i);
    if ($urandom_range(0, 7) == 0) return 22'h3FFFFF - 22'(i);
    return 22'(i) + 22'($urandom_range(0, 3)) * 22'h040;
  endfunction

  logic [AW-1:0] keep_addr;

  initial begin
    do_reset();

    // Single miss on slot 2: ack four cycles in, data five cycles after ack.
    set_req(2, 1'b1, 22'h00123);
    for (int c = 0; c <= 9; c++) begin
      sdram_ack = (c == 4);
      data_rdy  = (c == 9);
      data_read = (c == 9) ? 32'hDEADBEEF : 32'h0000_0000;
      sample();
      if (c == 1) check("miss_addr", 128'(sdram_addr), 128'(22'h00123));
      if (c == 9) check("miss_ok_early", 128'(slot_ok[2]), 128'd0);
      advance();
    end
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    sample();
    check("miss_ok", 128'(slot_ok[2]), 128'd1);
    check("miss_dout", 128'(slot_dout[2*DW +: DW]), 128'(32'hDEADBEEF));
    advance();

    // Re-request of the cached address is answered locally.
    set_req(2, 1'b0, 22'h00123);
    sample();
    advance();
    set_req(2, 1'b1, 22'h00123);
    sample();
    check("hit_ok", 128'(slot_ok[2]), 128'd1);
    check("hit_noreq", 128'(sdram_req), 128'd0);
    advance();
    sample();
    check("hit_noreq_next", 128'(sdram_req), 128'd0);
    advance();

    // Round-robin from reset, then slots 0 and 3 with last = 3.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 22'h000100 + 22'(i));
    run_capture(200, 4);
    drain(50);
    check("rr_count", 128'(grants.size()), 128'd4);
    for (int k = 0; k < 4; k++)
      check("rr_order", 128'((k < grants.size()) ? grants[k] : 22'h3FFFFF), 128'(22'h000100 + 22'(k)));
    set_req(1, 1'b0, '0);
    set_req(2, 1'b0, '0);
    set_req(0, 1'b1, 22'h000200);
    set_req(3, 1'b1, 22'h000203);
    run_capture(200, 2);
    drain(50);
    check("rr2_count", 128'(grants.size()), 128'd2);
    check("rr2_first", 128'((grants.size() > 0) ? grants[0] : 22'h3FFFFF), 128'(22'h000200));
    check("rr2_second", 128'((grants.size() > 1) ? grants[1] : 22'h3FFFFF), 128'(22'h000203));

    // Ack and data in the same cycle; next grant must follow at once.
    slot_req = '0;
    set_req(1, 1'b1, 22'h000555);
    sample();
    advance();
    sdram_ack = 1'b1;
    data_rdy  = 1'b1;
    data_read = 32'h12345678;
    sample();
    check("sim_req", 128'(sdram_req), 128'd1);
    advance();
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    set_req(0, 1'b1, 22'h000600);
    sample();
    check("sim_ok", 128'(slot_ok[1]), 128'd1);
    check("sim_dout", 128'(slot_dout[1*DW +: DW]), 128'(32'h12345678));
    check("sim_req_low", 128'(sdram_req), 128'd0);
    advance();
    sample();
    check("sim_next_req", 128'(sdram_req), 128'd1);
    check("sim_next_addr", 128'(sdram_addr), 128'(22'h000600));
    advance();
    drain(50);

    // loop_rst abort in WAIT_ACK: no cache write, request re-issued afterwards.
    slot_req = '0;
    set_req(0, 1'b1, 22'h000777);
    sample();
    advance();
    loop_rst  = 1'b1;
    sdram_ack = 1'b1;
    data_rdy  = 1'b1;
    data_read = 32'hBAD0BAD0;
    sample();
    check("abort_req_before", 128'(sdram_req), 128'd1);
    advance();
    loop_rst  = 1'b0;
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    sample();
    check("abort_req", 128'(sdram_req), 128'd0);
    check("abort_nowr", 128'(slot_ok[0]), 128'd0);
    advance();
    sample();
    check("abort_reissue", 128'(sdram_req), 128'd1);
    check("abort_addr", 128'(sdram_addr), 128'(22'h000777));
    advance();
    drain(50);

    // Download pulse invalidates every slot.
    slot_req  = '0;
    keep_addr = m_caddr[2];
    set_req(2, 1'b1, keep_addr);
    sample();
    check("dl_prehit", 128'(slot_ok[2]), 128'd1);
    advance();
    set_req(2, 1'b0, keep_addr);
    downloading = 1'b1;
    sample();
    advance();
    downloading = 1'b0;
    set_req(2, 1'b1, keep_addr);
    sample();
    check("dl_miss", 128'(slot_ok[2]), 128'd0);
    advance();
    sample();
    check("dl_reissue", 128'(sdram_req), 128'd1);
    check("dl_addr", 128'(sdram_addr), 128'(keep_addr));
    advance();
    drain(50);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (slot_req[i]) begin
          if (m_hit(i)) begin
            if ($urandom_range(0, 1) == 0) slot_req[i] = 1'b0;
          end else if ($urandom_range(0, 63) == 0) begin
            slot_addr[i*AW +: AW] = rand_addr(i);
          end
        end else if ($urandom_range(0, 2) == 0) begin
          set_req(i, 1'b1, rand_addr(i));
        end
      end
      downloading = ($urandom_range(0, 199) == 0);
      loop_rst    = ($urandom_range(0, 99) == 0);
      ctl_random();
      sample();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
